// File: rtl/iob_dma_read_arbiter.sv
// Round-robin scheduler sharing one iob_dma_read channel between N_REQ
// requesters. Each requester presents one descriptor (addr, length, max_len)
// with a valid flag. The winner gets a one-cycle ready pulse. Its descriptor
// is registered, the channel start is pulsed, and the channel busy flag is
// tracked until the transfer ends. A one-cycle done pulse then goes back to
// the owner.
//
// Handshake: a requester holds req_valid_i with its descriptor stable until
// it sees its req_ready_o bit high in a cycle with cke_i=1. That cycle is the
// accept. After it the requester may change or drop its inputs freely.
module iob_dma_read_arbiter #(
    parameter int N_REQ      = 4,
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_LEN_W  = 8,
    parameter int DMA_RLEN_W = 16,
    localparam int REQ_W     = $clog2(N_REQ)
) (
    input  logic                              clk_i,
    input  logic                              cke_i,
    input  logic                              arst_n_i,
    input  logic [N_REQ-1:0]                  req_valid_i,
    input  logic [N_REQ*AXI_ADDR_W-1:0]       req_addr_i,
    input  logic [N_REQ*DMA_RLEN_W-1:0]       req_length_i,
    input  logic [N_REQ*(AXI_LEN_W+1)-1:0]    req_max_len_i,
    output logic [N_REQ-1:0]                  req_ready_o,
    output logic [N_REQ-1:0]                  req_done_o,
    output logic [AXI_ADDR_W-1:0]             dma_addr_o,
    output logic [DMA_RLEN_W-1:0]             dma_length_o,
    output logic [AXI_LEN_W:0]                dma_max_len_o,
    output logic                              dma_start_o,
    input  logic                              dma_busy_i,
    output logic [REQ_W-1:0]                  owner_o,
    output logic                              owner_valid_o,
    output logic                              busy_o
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_START     = 2'd1;
    localparam logic [1:0] S_WAIT_BUSY = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;

    // Largest legal burst; zero or oversized requests are clamped to this so
    // the channel can never stall on a max_len of 0.
    localparam logic [AXI_LEN_W:0] MAX_BURST = {1'b1, {AXI_LEN_W{1'b0}}};

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [REQ_W-1:0]      r_last;
    logic [REQ_W-1:0]      r_owner;
    logic [AXI_ADDR_W-1:0] r_addr;
    logic [DMA_RLEN_W-1:0] r_length;
    logic [AXI_LEN_W:0]    r_max_len;

    logic [REQ_W-1:0]      w_winner;
    logic                  w_found;
    logic                  w_grant;
    logic                  w_done;
    logic [AXI_ADDR_W-1:0] w_sel_addr;
    logic [DMA_RLEN_W-1:0] w_sel_length;
    logic [AXI_LEN_W:0]    w_sel_max_len;
    logic [AXI_LEN_W:0]    w_clamped_max_len;

    // Round-robin search: first valid index after the last grantee, wrapping.
    always_comb begin
        int idx;
        idx      = 0;
        w_winner = '0;
        w_found  = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(r_last) + k) % N_REQ;
            if (!w_found && req_valid_i[idx]) begin
                w_found  = 1'b1;
                w_winner = REQ_W'(idx);
            end
        end
    end

    // A grant needs an idle FSM and a channel not in use by anyone else.
    assign w_grant = cke_i && (r_state == S_IDLE) && w_found && !dma_busy_i;
    assign w_done  = cke_i && (r_state == S_WAIT_DONE) && !dma_busy_i;

    assign w_sel_addr    = req_addr_i[int'(w_winner)*AXI_ADDR_W +: AXI_ADDR_W];
    assign w_sel_length  = req_length_i[int'(w_winner)*DMA_RLEN_W +: DMA_RLEN_W];
    assign w_sel_max_len = req_max_len_i[int'(w_winner)*(AXI_LEN_W+1) +: (AXI_LEN_W+1)];

    assign w_clamped_max_len = ((w_sel_max_len == '0) || (w_sel_max_len > MAX_BURST))
                               ? MAX_BURST : w_sel_max_len;

    // One-hot accept and completion pulses, both forced low while cke_i=0.
    always_comb begin
        req_ready_o = '0;
        req_done_o  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready_o[i] = w_grant && (w_winner == REQ_W'(i));
            req_done_o[i]  = w_done && (r_owner == REQ_W'(i));
        end
    end

    // Next-state logic for the grant / start / busy-tracking sequence.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:      if (w_grant)     w_state_next = S_START;
            S_START:                      w_state_next = S_WAIT_BUSY;
            S_WAIT_BUSY: if (dma_busy_i)  w_state_next = S_WAIT_DONE;
            S_WAIT_DONE: if (!dma_busy_i) w_state_next = S_IDLE;
            default:                      w_state_next = S_IDLE;
        endcase
    end

    // State, round-robin pointer and descriptor registers; everything holds
    // while cke_i=0.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state   <= S_IDLE;
            r_last    <= REQ_W'(N_REQ - 1);
            r_owner   <= '0;
            r_addr    <= '0;
            r_length  <= '0;
            r_max_len <= '0;
        end else if (cke_i) begin
            r_state <= w_state_next;
            if (w_grant) begin
                r_last    <= w_winner;
                r_owner   <= w_winner;
                r_addr    <= w_sel_addr;
                r_length  <= w_sel_length;
                r_max_len <= w_clamped_max_len;
            end
        end
    end

    assign dma_start_o   = cke_i && (r_state == S_START);
    assign dma_addr_o    = r_addr;
    assign dma_length_o  = r_length;
    assign dma_max_len_o = r_max_len;
    assign owner_o       = r_owner;
    assign owner_valid_o = (r_state != S_IDLE);
    assign busy_o        = (r_state != S_IDLE);

endmodule
